// File: rtl/ts_pkg.sv
// Shared types and constants for the temperature-sample conditioner.
package ts_pkg;

   localparam int unsigned TEMP_W = 16;

   localparam logic [TEMP_W-1:0] MIN_INIT = 16'h7FFF;
   localparam logic [TEMP_W-1:0] MAX_INIT = 16'h8000;

   // ADT7420 13-bit mode carries status flags in the low three bits.
   localparam logic [2:0]   FLAG_MASK = 3'b111;
   localparam int unsigned  FLAG_W    = $bits(FLAG_MASK);

   typedef enum logic {
      IDLE,
      WAIT_LSB
   } ts_state_e;

   // Convert an assembled register word to a signed sample.
   function automatic logic [TEMP_W-1:0] to_sample(input logic [TEMP_W-1:0] word,
                                                   input logic              res16);
      logic signed [TEMP_W-1:0] w;
      logic signed [TEMP_W-1:0] s13;
      w   = word;
      // Arithmetic shift drops the flag bits and sign-extends data[15:3].
      s13 = w >>> FLAG_W;
      return res16 ? word : s13;
   endfunction

endpackage

// File: rtl/ts_sample_conditioner_if.sv
// Byte-in / statistics-out bundle between the I2C driver, conditioner and wire-out path.
interface ts_sample_conditioner_if;
   import ts_pkg::*;

   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic              frame_start;
   logic              clear;
   logic [TEMP_W-1:0] sample_out;
   logic              sample_valid;
   logic [TEMP_W-1:0] avg_out;
   logic              avg_valid;
   logic [TEMP_W-1:0] min_out;
   logic [TEMP_W-1:0] max_out;
   logic [TEMP_W-1:0] sample_count;
   logic              frame_err;

   modport master (
      output rx_byte, rx_valid, frame_start, clear,
      input  sample_out, sample_valid, avg_out, avg_valid, min_out, max_out,
             sample_count, frame_err
   );

   modport slave (
      input  rx_byte, rx_valid, frame_start, clear,
      output sample_out, sample_valid, avg_out, avg_valid, min_out, max_out,
             sample_count, frame_err
   );

endinterface

// File: rtl/ts_boxcar_avg.sv
// Boxcar moving average over the last 2**LOG2_N samples with a running sum.
module ts_boxcar_avg
   import ts_pkg::*;
#(
   parameter int unsigned LOG2_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TEMP_W-1:0] sample,
   input  logic              strobe,
   input  logic              clear,
   output logic [TEMP_W-1:0] avg,
   output logic              avg_valid
);

   localparam int unsigned N     = 1 << LOG2_N;
   localparam int unsigned SUM_W = TEMP_W + LOG2_N;
   localparam logic [LOG2_N:0] FILL_FULL = (LOG2_N + 1)'(N);
   localparam logic [LOG2_N:0] FILL_LAST = (LOG2_N + 1)'(N - 1);

   logic [TEMP_W-1:0]        ring_q [N];
   logic [LOG2_N-1:0]        wr_ptr_q;
   logic [LOG2_N:0]          fill_q;
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [SUM_W-1:0]  sum_d;
   logic signed [SUM_W-1:0]  oldest;
   logic signed [SUM_W-1:0]  newest;

   // Next running sum: add the new sample, retire the oldest once the window is full.
   always_comb begin
      newest = {{LOG2_N{sample[TEMP_W-1]}}, sample};
      oldest = '0;
      if (fill_q == FILL_FULL) begin
         oldest = {{LOG2_N{ring_q[wr_ptr_q][TEMP_W-1]}}, ring_q[wr_ptr_q]};
      end
      sum_d = sum_q + newest - oldest;
   end

   // Window state; clear and reset both return everything to empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) ring_q[i] <= '0;
         wr_ptr_q  <= '0;
         fill_q    <= '0;
         sum_q     <= '0;
         avg       <= '0;
         avg_valid <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < N; i++) ring_q[i] <= '0;
         wr_ptr_q  <= '0;
         fill_q    <= '0;
         sum_q     <= '0;
         avg       <= '0;
         avg_valid <= 1'b0;
      end else if (strobe) begin
         ring_q[wr_ptr_q] <= sample;
         wr_ptr_q         <= wr_ptr_q + LOG2_N'(1);
         sum_q            <= sum_d;
         // Dropping the low LOG2_N bits is an arithmetic shift (floor division by N).
         avg              <= sum_d[LOG2_N +: TEMP_W];
         if (fill_q != FILL_FULL) fill_q <= fill_q + (LOG2_N + 1)'(1);
         if (fill_q == FILL_LAST) avg_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/ts_sample_conditioner.sv
// Assembles ADT7420 MSB/LSB byte pairs into samples and keeps running statistics.
module ts_sample_conditioner
   import ts_pkg::*;
#(
   parameter bit          RES16       = 1'b0,
   parameter int unsigned LOG2_N      = 3,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input logic                    clk,
   input logic                    rst,
   ts_sample_conditioner_if.slave bus
);

   localparam int unsigned  TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   ts_state_e         state_q;
   logic [7:0]        msb_q;
   logic [TMO_W-1:0]  tmo_q;
   logic [TEMP_W-1:0] sample_q;
   logic              sample_valid_q;
   logic              frame_err_q;
   logic [TEMP_W-1:0] min_q;
   logic [TEMP_W-1:0] max_q;
   logic [TEMP_W-1:0] count_q;
   logic [TEMP_W-1:0] avg;
   logic              avg_valid;

   // Byte assembler: pairs a frame_start MSB with the following LSB, flags anything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         msb_q          <= '0;
         tmo_q          <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.rx_valid) begin
                  if (bus.frame_start) begin
                     msb_q   <= bus.rx_byte;
                     tmo_q   <= '0;
                     state_q <= WAIT_LSB;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
            end
            WAIT_LSB: begin
               if (bus.rx_valid) begin
                  if (bus.frame_start) begin
                     // A fresh MSB supersedes the pending one.
                     frame_err_q <= 1'b1;
                     msb_q       <= bus.rx_byte;
                     tmo_q       <= '0;
                  end else begin
                     sample_q       <= to_sample({msb_q, bus.rx_byte}, RES16);
                     sample_valid_q <= 1'b1;
                     state_q        <= IDLE;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  frame_err_q <= 1'b1;
                  msb_q       <= '0;
                  state_q     <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Min/max/count track samples one cycle after sample_valid; clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_q   <= MIN_INIT;
         max_q   <= MAX_INIT;
         count_q <= '0;
      end else if (bus.clear) begin
         min_q   <= MIN_INIT;
         max_q   <= MAX_INIT;
         count_q <= '0;
      end else if (sample_valid_q) begin
         if ($signed(sample_q) < $signed(min_q)) min_q <= sample_q;
         if ($signed(sample_q) > $signed(max_q)) max_q <= sample_q;
         if (count_q != '1) count_q <= count_q + TEMP_W'(1);
      end
   end

   ts_boxcar_avg #(
      .LOG2_N (LOG2_N)
   ) u_boxcar (
      .clk       (clk),
      .rst       (rst),
      .sample    (sample_q),
      .strobe    (sample_valid_q),
      .clear     (bus.clear),
      .avg       (avg),
      .avg_valid (avg_valid)
   );

   assign bus.sample_out   = sample_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.avg_out      = avg;
   assign bus.avg_valid    = avg_valid;
   assign bus.min_out      = min_q;
   assign bus.max_out      = max_q;
   assign bus.sample_count = count_q;
   assign bus.frame_err    = frame_err_q;

endmodule

// File: doc/ts_sample_conditioner.md
Name: ts_sample_conditioner

Overview:
- Sits directly downstream of the I2C byte driver, alongside the temperature-sensor controller.
- Consumes received bytes from ADT7420 temperature-register reads, assembles MSB/LSB pairs into signed temperature samples, and keeps a boxcar moving average plus min/max/count statistics.
- Outputs are registered values that the PC wire-out path reads.

Parameters:
- RES16, 0, 1 = ADT7420 16-bit mode (full word); 0 = 13-bit mode (data[15:3], sign-extended to 16).
- LOG2_N, 3, log2 of averaging window length (N = 8).
- TIMEOUT_CYC, 200000, max clk cycles allowed between MSB and LSB bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_byte  in  8  byte received from the I2C driver
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle
- frame_start  in  1  qualifies rx_valid: this byte is the MSB of a temperature read
- clear  in  1  synchronous statistics clear, one cycle
- sample_out  out  16  latest signed sample, 1/16 °C (13-bit) or 1/128 °C (16-bit)
- sample_valid  out  1  one-cycle pulse when sample_out updates
- avg_out  out  16  signed moving average of the last N samples
- avg_valid  out  1  level; high once N samples have been accumulated since reset/clear
- min_out  out  16  signed minimum since reset/clear
- max_out  out  16  signed maximum since reset/clear
- sample_count  out  16  samples since reset/clear, saturating at 0xFFFF
- frame_err  out  1  one-cycle pulse on a framing violation or timeout

Behaviour:
- Reset values:
  - sample_out, avg_out, sample_count = 0.
  - sample_valid, avg_valid, frame_err = 0.
  - min_out = 0x7FFF, max_out = 0x8000.
  - FSM in IDLE; buffer, running sum and fill counter = 0.
- Assembler FSM, states IDLE and WAIT_LSB:
  - IDLE, rx_valid & frame_start: latch MSB, clear timeout counter, go to WAIT_LSB.
  - IDLE, rx_valid & !frame_start: pulse frame_err, drop the byte, stay in IDLE.
  - WAIT_LSB, rx_valid & !frame_start: latch LSB, form word = {MSB, LSB}, go to IDLE.
  - WAIT_LSB, rx_valid & frame_start: pulse frame_err, latch the new MSB, stay in WAIT_LSB, restart timeout.
  - WAIT_LSB, timeout counter reaches TIMEOUT_CYC with no byte: pulse frame_err, go to IDLE, discard MSB.
- Sample conversion:
  - RES16=0: sample = sign-extend(word[15:3]); flag bits [2:0] are ignored.
  - RES16=1: sample = word.
- Latency:
  - sample_out and sample_valid update on the clock edge after the LSB strobe (1 cycle).
  - avg_out, min_out, max_out and sample_count update one cycle after sample_valid (2 cycles after the LSB).
- Moving average:
  - Circular buffer of N × 16-bit entries; write pointer wraps modulo N.
  - Running sum is signed, 16+LOG2_N bits.
  - On each sample: sum <= sum + new − oldest, where oldest = 0 while the buffer is not yet full.
  - avg_out = sum >>> LOG2_N (arithmetic shift, truncates toward −inf).
  - avg_valid rises on the update of the Nth sample and stays high until clear/rst.
  - avg_out is updated even while avg_valid = 0 (partial sum / N).
- min/max: signed compare; update when the new sample < min_out or > max_out.
- clear:
  - Resets buffer, sum, fill counter, avg_out, avg_valid, sample_count and min/max to their reset values.
  - Does not affect the assembler FSM or sample_out.
- clear coinciding with a statistics update: clear wins, and that sample is excluded from the statistics.
- rst mid-frame: FSM returns to IDLE immediately and the partial MSB is lost.
- rx_valid must not be asserted on consecutive cycles (driver byte rate ≫ 1 cycle); behaviour is defined regardless, since every strobe is processed.

Decomposition:
- Shared package ts_pkg:
  - TEMP_W = 16.
  - MIN_INIT = 16'h7FFF, MAX_INIT = 16'h8000.
  - ADT7420 flag-bit mask 3'b111.
  - FSM state enum {IDLE, WAIT_LSB}.
- Sub-module ts_boxcar_avg (parameter LOG2_N): circular buffer, running sum, fill counter and avg_valid. Its inputs are sample, strobe and clear.
- The assembler FSM, conversion and min/max/count logic stay in the top module.

Test Plan:
- RES16=0; MSB 0x0C (frame_start), then LSB 0x80 → sample_out = 0x0190 (400 = 25.0 °C), sample_valid pulses 1 cycle after the LSB; next cycle min = max = 0x0190, count = 1.
- RES16=0; bytes 0xFF, 0x80 → sample_out = 0xFFF0 (−16 = −1.0 °C); min_out = 0xFFF0.
- Averaging window:
  - Eight frames of 400 → avg_valid rises with the 8th update, avg_out = 400.
  - A ninth frame of 480 → avg_out = 410 (sum 3280 >>> 3), count = 9, max = 480.
- Framing errors:
  - LSB strobe with no MSB in IDLE → frame_err pulse, no sample_valid.
  - MSB, MSB, LSB → one frame_err, and the sample is built from the second MSB.
  - MSB then silence for TIMEOUT_CYC cycles (bench sets TIMEOUT_CYC = 100) → frame_err on the 100th cycle, FSM back in IDLE, a later lone LSB causes another frame_err.
- clear asserted on the same cycle as a statistics update after 5 samples → count = 0, avg_valid = 0, min = 0x7FFF, max = 0x8000; sample_out still shows the new sample.
- rst asserted between MSB and LSB → all outputs at reset values asynchronously; after release, LSB alone → frame_err, no sample.
